// File: rtl/spram_access_ctrl_pkg.sv
// Shared definitions for SPRAM256X16 pin-level wrappers: FSM encoding and default geometry.
package spram_access_ctrl_pkg;

  localparam int unsigned SPRAM_AW      = 8;
  localparam int unsigned SPRAM_DW      = 16;
  localparam int unsigned SPRAM_TMO_CYC = 15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_GAP    = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/spram_tmo_cnt.sv
// Wait counter for a macro access: cleared on access entry, flags the cycle that reaches TMO_CYC.
module spram_tmo_cnt #(
  parameter int unsigned TMO_CYC = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic tc_c
);

  localparam int unsigned CW = $clog2(TMO_CYC + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CW'(1);
    end
  end

  // High on the increment that makes the count equal TMO_CYC.
  assign tc_c = inc && (cnt == CW'(TMO_CYC - 1));

endmodule

// File: rtl/spram_access_ctrl.sv
// Valid/ready command front end for one SPRAM256X16: single writes, burst reads, READY timeout.
module spram_access_ctrl
  import spram_access_ctrl_pkg::*;
#(
  parameter int unsigned AW      = SPRAM_AW,
  parameter int unsigned DW      = SPRAM_DW,
  parameter int unsigned TMO_CYC = SPRAM_TMO_CYC
) (
  input  logic          CLK,
  input  logic          NRST,
  input  logic          CMD_VALID,
  output logic          CMD_READY,
  input  logic          CMD_WR,
  input  logic [AW-1:0] CMD_AD,
  input  logic [AW-1:0] CMD_LEN,
  input  logic [DW-1:0] CMD_DI,
  output logic          RSP_VALID,
  input  logic          RSP_READY,
  output logic [DW-1:0] RSP_DO,
  output logic          RSP_LAST,
  output logic          RSP_ERR,
  output logic          BUSY,
  output logic          CS,
  output logic          EN,
  output logic          RD,
  output logic          WR,
  output logic [AW-1:0] AD,
  output logic [DW-1:0] DI,
  input  logic          READY,
  input  logic [DW-1:0] DO
);

  state_t        state, state_d;
  logic [AW-1:0] beat, beat_d;
  logic          cmd_ready_d, rsp_valid_d, rsp_last_d, rsp_err_d, busy_d;
  logic          cs_d, en_d, rd_d, wr_d;
  logic [DW-1:0] rsp_do_d, di_d;
  logic [AW-1:0] ad_d;
  logic          tmo_clr, tmo_inc, tmo_tc_c;

  spram_tmo_cnt #(.TMO_CYC(TMO_CYC)) u_tmo_cnt (
    .clk  (CLK),
    .rst_n(NRST),
    .clr  (tmo_clr),
    .inc  (tmo_inc),
    .tc_c (tmo_tc_c)
  );

  // State and registered outputs.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      state     <= ST_IDLE;
      beat      <= '0;
      CMD_READY <= 1'b0;
      RSP_VALID <= 1'b0;
      RSP_DO    <= '0;
      RSP_LAST  <= 1'b0;
      RSP_ERR   <= 1'b0;
      BUSY      <= 1'b0;
      CS        <= 1'b0;
      EN        <= 1'b0;
      RD        <= 1'b0;
      WR        <= 1'b0;
      AD        <= '0;
      DI        <= '0;
    end else begin
      state     <= state_d;
      beat      <= beat_d;
      CMD_READY <= cmd_ready_d;
      RSP_VALID <= rsp_valid_d;
      RSP_DO    <= rsp_do_d;
      RSP_LAST  <= rsp_last_d;
      RSP_ERR   <= rsp_err_d;
      BUSY      <= busy_d;
      CS        <= cs_d;
      EN        <= en_d;
      RD        <= rd_d;
      WR        <= wr_d;
      AD        <= ad_d;
      DI        <= di_d;
    end
  end

  // Next state and next output values; everything holds unless a transition says otherwise.
  always_comb begin
    state_d     = state;
    beat_d      = beat;
    cmd_ready_d = CMD_READY;
    rsp_valid_d = RSP_VALID;
    rsp_do_d    = RSP_DO;
    rsp_last_d  = RSP_LAST;
    rsp_err_d   = RSP_ERR;
    busy_d      = BUSY;
    cs_d        = CS;
    en_d        = EN;
    rd_d        = RD;
    wr_d        = WR;
    ad_d        = AD;
    di_d        = DI;
    tmo_clr     = 1'b0;
    tmo_inc     = 1'b0;

    unique case (state)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (CMD_VALID && CMD_READY) begin
          state_d     = ST_ACCESS;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          cs_d        = 1'b1;
          en_d        = 1'b1;
          rd_d        = !CMD_WR;
          wr_d        = CMD_WR;
          ad_d        = CMD_AD;
          di_d        = CMD_DI;
          beat_d      = CMD_WR ? '0 : CMD_LEN;
          tmo_clr     = 1'b1;
        end
      end

      ST_ACCESS: begin
        tmo_inc = 1'b1;
        // READY wins over a timeout landing in the same cycle.
        if (READY) begin
          state_d     = ST_RESP;
          rd_d        = 1'b0;
          wr_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_do_d    = RD ? DO : '0;
          rsp_last_d  = (beat == '0);
          rsp_err_d   = 1'b0;
        end else if (tmo_tc_c) begin
          state_d     = ST_RESP;
          cs_d        = 1'b0;
          en_d        = 1'b0;
          rd_d        = 1'b0;
          wr_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_do_d    = '0;
          rsp_last_d  = 1'b1;
          rsp_err_d   = 1'b1;
        end
      end

      ST_RESP: begin
        if (RSP_READY) begin
          rsp_valid_d = 1'b0;
          rsp_do_d    = '0;
          rsp_last_d  = 1'b0;
          rsp_err_d   = 1'b0;
          if (RSP_LAST) begin
            state_d     = ST_IDLE;
            cs_d        = 1'b0;
            en_d        = 1'b0;
            busy_d      = 1'b0;
            cmd_ready_d = 1'b1;
          end else begin
            state_d = ST_GAP;
            ad_d    = AD + AW'(1);
            beat_d  = beat - AW'(1);
          end
        end
      end

      ST_GAP: begin
        state_d = ST_ACCESS;
        rd_d    = 1'b1;
        tmo_clr = 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_spram_access_ctrl.sv
// Directed bench for spram_access_ctrl against a behavioural SPRAM256X16 with programmable READY delay.
module tb_spram_access_ctrl;

  logic        CLK = 1'b0;
  logic        NRST;
  logic        CMD_VALID, CMD_READY, CMD_WR;
  logic [7:0]  CMD_AD, CMD_LEN;
  logic [15:0] CMD_DI;
  logic        RSP_VALID, RSP_READY, RSP_LAST, RSP_ERR, BUSY;
  logic [15:0] RSP_DO;
  logic        CS, EN, RD, WR, READY;
  logic [7:0]  AD;
  logic [15:0] DI, DO;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  spram_access_ctrl dut (
    .CLK(CLK), .NRST(NRST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WR(CMD_WR),
    .CMD_AD(CMD_AD), .CMD_LEN(CMD_LEN), .CMD_DI(CMD_DI),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DO(RSP_DO),
    .RSP_LAST(RSP_LAST), .RSP_ERR(RSP_ERR), .BUSY(BUSY),
    .CS(CS), .EN(EN), .RD(RD), .WR(WR), .AD(AD), .DI(DI),
    .READY(READY), .DO(DO)
  );

  // Behavioural macro: READY rises after dly cycles of RD/WR, never when stuck.
  logic [15:0] mem [256];
  int          dly   = 0;
  bit          stuck = 1'b0;
  int          acc_cnt = 0;

  assign READY = (RD || WR) && !stuck && (acc_cnt >= dly);
  assign DO    = (RD && READY) ? mem[AD] : 16'h0;

  always @(posedge CLK) begin
    acc_cnt <= (RD || WR) ? acc_cnt + 1 : 0;
    if (WR && READY) mem[AD] <= DI;
  end

  // Pulse monitor: length, address, kind of each RD/WR pulse and idle cycles before it.
  int         len_q [$];
  int         gap_q [$];
  logic [7:0] ad_q  [$];
  bit         isw_q [$];
  int         run = 0, idle_run = 0, both_cnt = 0, unstable_cnt = 0;
  logic [7:0] start_ad;
  bit         start_w;

  always @(negedge CLK) begin
    if (RD && WR) both_cnt++;
    if (RD || WR) begin
      if (run == 0) begin
        start_ad = AD;
        start_w  = WR;
        gap_q.push_back(idle_run);
      end else if (AD !== start_ad || WR !== start_w || !CS || !EN) begin
        unstable_cnt++;
      end
      run++;
      idle_run = 0;
    end else begin
      if (run > 0) begin
        len_q.push_back(run);
        ad_q.push_back(start_ad);
        isw_q.push_back(start_w);
        run = 0;
      end
      idle_run++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_cmd(input logic wr, input logic [7:0] ad, input logic [7:0] len,
                          input logic [15:0] di);
    bit done = 1'b0;
    CMD_VALID = 1'b1; CMD_WR = wr; CMD_AD = ad; CMD_LEN = len; CMD_DI = di;
    for (int i = 0; i < 60 && !done; i++) begin
      if (CMD_READY) done = 1'b1;
      @(negedge CLK);
    end
    CMD_VALID = 1'b0;
    chk("cmd_accept", 64'(done), 64'd1);
  endtask

  // Called at a negedge with RSP_READY=1; returns at the negedge after the handshake.
  task automatic wait_rsp(output logic [15:0] d, output logic last, output logic err,
                          output logic [3:0] ctl, output int waits);
    bit found = 1'b0;
    d = '0; last = 1'b0; err = 1'b0; ctl = '0; waits = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (RSP_VALID) begin
        found = 1'b1;
        d = RSP_DO; last = RSP_LAST; err = RSP_ERR; ctl = {CS, EN, RD, WR};
      end else begin
        waits++;
      end
      @(negedge CLK);
    end
    chk("rsp_seen", 64'(found), 64'd1);
  endtask

  function automatic logic [63:0] all_out();
    return 64'({CMD_READY, RSP_VALID, RSP_DO, RSP_LAST, RSP_ERR, BUSY,
                CS, EN, RD, WR, AD, DI});
  endfunction

  logic [15:0] d;
  logic        last, err;
  logic [3:0]  ctl;
  int          waits, base, n, bad;
  int          acc_cyc [3];

  initial begin
    NRST = 1'b0; CMD_VALID = 1'b0; CMD_WR = 1'b0; CMD_AD = '0; CMD_LEN = '0;
    CMD_DI = '0; RSP_READY = 1'b1;
    repeat (3) @(negedge CLK);
    chk("reset_outputs", all_out(), 64'd0);
    NRST = 1'b1;
    @(negedge CLK);
    chk("idle_cmd_ready", 64'({CMD_READY, BUSY}), 64'b10);

    // Case 1: single write, READY delay 2 -> 3-cycle WR pulse.
    dly = 2;
    send_cmd(1'b1, 8'h10, 8'h0, 16'hA5C3);
    chk("wr_pins", 64'({CS, EN, RD, WR, AD, DI}), 64'({4'b1101, 8'h10, 16'hA5C3}));
    wait_rsp(d, last, err, ctl, waits);
    chk("wr_rsp", 64'({d, last, err}), 64'({16'h0, 2'b10}));
    chk("wr_latency", 64'(waits), 64'd3);
    chk("wr_pulse_len", 64'(len_q[len_q.size()-1]), 64'd3);
    chk("wr_pulse_kind", 64'({isw_q[isw_q.size()-1], ad_q[ad_q.size()-1]}), 64'({1'b1, 8'h10}));
    chk("wr_mem", 64'(mem[8'h10]), 64'hA5C3);
    chk("wr_back_idle", 64'({CMD_READY, BUSY, CS, EN}), 64'b1000);

    // Preload 0xFE..0x01 with 1..4 through the controller.
    dly = 0;
    for (int i = 0; i < 4; i++) begin
      send_cmd(1'b1, 8'hFE + 8'(i), 8'h0, 16'(i + 1));
      wait_rsp(d, last, err, ctl, waits);
    end
    chk("preload_mem", 64'({mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01]}),
        64'h0001_0002_0003_0004);

    // Case 2: wrapping burst read, zero delay.
    base = len_q.size();
    send_cmd(1'b0, 8'hFE, 8'h3, 16'h0);
    for (int i = 0; i < 4; i++) begin
      wait_rsp(d, last, err, ctl, waits);
      chk("burst_beat", 64'({d, last, err}), 64'({16'(i + 1), (i == 3), 1'b0}));
      if (i == 0) chk("burst_latency", 64'(waits), 64'd1);
    end
    chk("burst_pulses", 64'(len_q.size() - base), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("burst_pulse", 64'({isw_q[base+i], ad_q[base+i], 8'(len_q[base+i])}),
          64'({1'b0, 8'hFE + 8'(i), 8'd1}));
      if (i > 0) chk("burst_gap", 64'(gap_q[base+i]), 64'd2);
    end
    chk("burst_back_idle", 64'({CMD_READY, BUSY}), 64'b10);

    // Case 3: back-pressure on beat 2 holds the response and blocks the next RD.
    base = len_q.size();
    send_cmd(1'b0, 8'hFE, 8'h3, 16'h0);
    wait_rsp(d, last, err, ctl, waits);
    chk("bp_beat1", 64'(d), 64'd1);
    RSP_READY = 1'b0;
    for (int i = 0; i < 20 && !RSP_VALID; i++) @(negedge CLK);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if ({RSP_VALID, RSP_DO, RSP_LAST, RD} !== {1'b1, 16'h2, 1'b0, 1'b0}) bad++;
      @(negedge CLK);
    end
    chk("bp_hold_stable", 64'(bad), 64'd0);
    chk("bp_no_new_rd", 64'(len_q.size() - base), 64'd2);
    RSP_READY = 1'b1;
    for (int i = 1; i < 4; i++) begin
      wait_rsp(d, last, err, ctl, waits);
      chk("bp_beat", 64'({d, last}), 64'({16'(i + 1), (i == 3)}));
    end

    // Case 4: READY stuck low -> abort after 15 ACCESS cycles.
    stuck = 1'b1;
    send_cmd(1'b0, 8'h40, 8'h2, 16'h0);
    wait_rsp(d, last, err, ctl, waits);
    chk("tmo_rsp", 64'({d, last, err}), 64'({16'h0, 2'b11}));
    chk("tmo_ctl_dropped", 64'(ctl), 64'd0);
    chk("tmo_wait_cycles", 64'(waits), 64'd15);
    chk("tmo_rd_len", 64'(len_q[len_q.size()-1]), 64'd15);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (RSP_VALID || RD) bad++;
      @(negedge CLK);
    end
    chk("tmo_single_rsp", 64'(bad), 64'd0);
    chk("tmo_back_idle", 64'({CMD_READY, BUSY}), 64'b10);
    stuck = 1'b0;

    // Case 5: reset in the middle of a burst access.
    dly = 3;
    send_cmd(1'b0, 8'h20, 8'h3, 16'h0);
    @(negedge CLK);
    chk("rst_mid_access_rd", 64'(RD), 64'd1);
    NRST = 1'b0;
    @(negedge CLK);
    chk("rst_mid_outputs", all_out(), 64'd0);
    NRST = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (RSP_VALID || RD) bad++;
      @(negedge CLK);
    end
    chk("rst_no_rsp", 64'(bad), 64'd0);
    dly = 1;
    send_cmd(1'b1, 8'h33, 8'h0, 16'h1234);
    wait_rsp(d, last, err, ctl, waits);
    chk("rst_then_write", 64'({last, err, mem[8'h33]}), 64'({2'b10, 16'h1234}));

    // Case 6: CMD_VALID held high across three writes.
    dly = 0;
    base = len_q.size();
    n = 0;
    CMD_VALID = 1'b1; CMD_WR = 1'b1; CMD_AD = 8'h50; CMD_LEN = 8'h7; CMD_DI = 16'hC000;
    for (int cyc = 0; cyc < 60 && n < 3; cyc++) begin
      if (CMD_READY) begin
        acc_cyc[n] = cyc;
        n++;
      end
      @(negedge CLK);
      if (n < 3) begin
        CMD_AD = 8'h50 + 8'(n);
        CMD_DI = 16'hC000 + 16'(n);
      end else begin
        CMD_VALID = 1'b0;
      end
    end
    CMD_VALID = 1'b0;
    repeat (4) @(negedge CLK);
    chk("b2b_accepts", 64'(n), 64'd3);
    chk("b2b_spacing1", 64'(acc_cyc[1] - acc_cyc[0]), 64'd3);
    chk("b2b_spacing2", 64'(acc_cyc[2] - acc_cyc[1]), 64'd3);
    chk("b2b_mem", 64'({mem[8'h50], mem[8'h51], mem[8'h52]}), 64'h0000_C000_C001_C002);
    chk("b2b_pulses", 64'(len_q.size() - base), 64'd3);
    chk("b2b_idle", 64'({CMD_READY, BUSY, RSP_VALID}), 64'b100);

    chk("rd_wr_never_both", 64'(both_cnt), 64'd0);
    chk("pins_stable_in_access", 64'(unstable_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
